// File: rtl/clock_display_if.sv
// ----------------------------------------------------------------------------
// clock_display_if
//   Groups the time inputs, request/status handshake and the six seven-segment
//   pattern outputs of clock_display into one bundle.
//
//   Signals
//     i_sec, i_min  6-bit binary seconds / minutes
//     i_h           5-bit binary hours
//     i_valid       request: sample the time fields and start a conversion
//     o_busy        conversion in progress
//     o_done        one-cycle pulse when new patterns are loaded
//     o_sec0..o_h1  7-bit segment patterns {g,f,e,d,c,b,a}, units (0) / tens (1)
//
//   Modports
//     master  drives the time fields and i_valid, observes results
//     slave   the converter side (clock_display)
// ----------------------------------------------------------------------------
interface clock_display_if;
    logic [5:0] i_sec;
    logic [5:0] i_min;
    logic [4:0] i_h;
    logic       i_valid;
    logic       o_busy;
    logic       o_done;
    logic [6:0] o_sec0;
    logic [6:0] o_sec1;
    logic [6:0] o_min0;
    logic [6:0] o_min1;
    logic [6:0] o_h0;
    logic [6:0] o_h1;

    modport master (
        output i_sec, i_min, i_h, i_valid,
        input  o_busy, o_done, o_sec0, o_sec1, o_min0, o_min1, o_h0, o_h1
    );

    modport slave (
        input  i_sec, i_min, i_h, i_valid,
        output o_busy, o_done, o_sec0, o_sec1, o_min0, o_min1, o_h0, o_h1
    );
endinterface

// File: rtl/clock_display.sv
// ----------------------------------------------------------------------------
// clock_display
//   Converts a binary hh:mm:ss time into six seven-segment digit patterns.
//   A request samples the three fields, runs six double-dabble iterations on
//   all fields in parallel, then decodes the BCD nibbles and loads the pattern
//   registers in a single cycle, pulsing o_done. Patterns hold between
//   conversions; requests arriving while busy are dropped.
//
//   Parameters
//     SEG_ACTIVE_LOW  1: segment lit when its bit is 0; 0: lit when bit is 1
//
//   Ports
//     clk    clock, rising edge
//     i_rst  asynchronous active-high reset
//     bus    clock_display_if.slave (time inputs, handshake, pattern outputs)
// ----------------------------------------------------------------------------
module clock_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic              clk,
    input logic              i_rst,
    clock_display_if.slave   bus
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StOut
    } state_e;

    // Six iterations cover the 6-bit binary width of every field.
    localparam logic [2:0] LastIter = 3'd5;

    // Pattern for digit "0" in the selected polarity; used as the reset value.
    localparam logic [6:0] SegZero = SEG_ACTIVE_LOW ? 7'b1000000 : 7'b0111111;

    state_e     state_q, state_d;
    logic [2:0] iter_q, iter_d;

    logic [5:0] sec_bin_q, sec_bin_d;
    logic [5:0] min_bin_q, min_bin_d;
    logic [5:0] h_bin_q, h_bin_d;
    logic [7:0] sec_bcd_q, sec_bcd_d;
    logic [7:0] min_bcd_q, min_bcd_d;
    logic [7:0] h_bcd_q, h_bcd_d;

    logic       done_q, done_d;
    logic [6:0] sec0_q, sec0_d;
    logic [6:0] sec1_q, sec1_d;
    logic [6:0] min0_q, min0_d;
    logic [6:0] min1_q, min1_d;
    logic [6:0] h0_q, h0_d;
    logic [6:0] h1_q, h1_d;

    // One double-dabble iteration: correct each nibble >= 5 by +3, then shift
    // the concatenation {bcd, bin} left by one. Returns {bcd_next, bin_next}.
    function automatic logic [13:0] dd_step(input logic [7:0] bcd, input logic [5:0] bin);
        logic [7:0] adj;
        adj = bcd;
        if (adj[3:0] >= 4'd5) begin
            adj[3:0] = adj[3:0] + 4'd3;
        end
        if (adj[7:4] >= 4'd5) begin
            adj[7:4] = adj[7:4] + 4'd3;
        end
        return {adj[6:0], bin, 1'b0};
    endfunction

    // BCD nibble to segment pattern; codes 10-15 render blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat_al;
        case (nib)
            4'd0:    pat_al = 7'b1000000;
            4'd1:    pat_al = 7'b1111001;
            4'd2:    pat_al = 7'b0100100;
            4'd3:    pat_al = 7'b0110000;
            4'd4:    pat_al = 7'b0011001;
            4'd5:    pat_al = 7'b0010010;
            4'd6:    pat_al = 7'b0000010;
            4'd7:    pat_al = 7'b1111000;
            4'd8:    pat_al = 7'b0000000;
            4'd9:    pat_al = 7'b0010000;
            default: pat_al = 7'b1111111;
        endcase
        return SEG_ACTIVE_LOW ? pat_al : ~pat_al;
    endfunction

    always_comb begin
        state_d   = state_q;
        iter_d    = iter_q;
        sec_bin_d = sec_bin_q;
        min_bin_d = min_bin_q;
        h_bin_d   = h_bin_q;
        sec_bcd_d = sec_bcd_q;
        min_bcd_d = min_bcd_q;
        h_bcd_d   = h_bcd_q;
        done_d    = 1'b0;
        sec0_d    = sec0_q;
        sec1_d    = sec1_q;
        min0_d    = min0_q;
        min1_d    = min1_q;
        h0_d      = h0_q;
        h1_d      = h1_q;

        unique case (state_q)
            StIdle: begin
                if (bus.i_valid) begin
                    sec_bin_d = bus.i_sec;
                    min_bin_d = bus.i_min;
                    h_bin_d   = {1'b0, bus.i_h};
                    sec_bcd_d = '0;
                    min_bcd_d = '0;
                    h_bcd_d   = '0;
                    iter_d    = '0;
                    state_d   = StShift;
                end
            end
            StShift: begin
                {sec_bcd_d, sec_bin_d} = dd_step(sec_bcd_q, sec_bin_q);
                {min_bcd_d, min_bin_d} = dd_step(min_bcd_q, min_bin_q);
                {h_bcd_d, h_bin_d}     = dd_step(h_bcd_q, h_bin_q);
                iter_d = iter_q + 3'd1;
                if (iter_q == LastIter) begin
                    state_d = StOut;
                end
            end
            StOut: begin
                sec0_d  = seg_decode(sec_bcd_q[3:0]);
                sec1_d  = seg_decode(sec_bcd_q[7:4]);
                min0_d  = seg_decode(min_bcd_q[3:0]);
                min1_d  = seg_decode(min_bcd_q[7:4]);
                h0_d    = seg_decode(h_bcd_q[3:0]);
                h1_d    = seg_decode(h_bcd_q[7:4]);
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= StIdle;
            iter_q    <= '0;
            sec_bin_q <= '0;
            min_bin_q <= '0;
            h_bin_q   <= '0;
            sec_bcd_q <= '0;
            min_bcd_q <= '0;
            h_bcd_q   <= '0;
            done_q    <= 1'b0;
            sec0_q    <= SegZero;
            sec1_q    <= SegZero;
            min0_q    <= SegZero;
            min1_q    <= SegZero;
            h0_q      <= SegZero;
            h1_q      <= SegZero;
        end else begin
            state_q   <= state_d;
            iter_q    <= iter_d;
            sec_bin_q <= sec_bin_d;
            min_bin_q <= min_bin_d;
            h_bin_q   <= h_bin_d;
            sec_bcd_q <= sec_bcd_d;
            min_bcd_q <= min_bcd_d;
            h_bcd_q   <= h_bcd_d;
            done_q    <= done_d;
            sec0_q    <= sec0_d;
            sec1_q    <= sec1_d;
            min0_q    <= min0_d;
            min1_q    <= min1_d;
            h0_q      <= h0_d;
            h1_q      <= h1_d;
        end
    end

    // Busy is decoded straight from the state so reset clears it immediately.
    assign bus.o_busy = (state_q != StIdle);
    assign bus.o_done = done_q;
    assign bus.o_sec0 = sec0_q;
    assign bus.o_sec1 = sec1_q;
    assign bus.o_min0 = min0_q;
    assign bus.o_min1 = min1_q;
    assign bus.o_h0   = h0_q;
    assign bus.o_h1   = h1_q;

endmodule
